// File: rtl/accel_dma_shell.sv
// accel_dma_shell: generic memory-to-kernel shell.
// Fetches N words (stride step) into an input buffer, hands both buffers to an
// HLS-style kernel via k_start/k_done, then streams the output buffer back to memory.
// Optional build macro: CYCLE_COUNTER_EN adds the cycle_count[31:0] output.
module accel_dma_shell #(
    parameter int unsigned DATA_WID = 32,
    parameter int unsigned ADDR_WID = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [63:0]         read_base,
    input  logic [63:0]         write_base,
    input  logic [63:0]         num_words,
    input  logic [63:0]         step,
    input  logic                read_ready,
    input  logic [DATA_WID-1:0] read_data,
    input  logic                write_ready,
    output logic                read_enable,
    output logic [63:0]         read_addr,
    output logic [63:0]         read_size,
    output logic                finish_read,
    output logic                write_enable,
    output logic [63:0]         write_addr,
    output logic [63:0]         write_size,
    output logic                finish_write,
    output logic [DATA_WID-1:0] write_data,
    output logic                busy,
    output logic                done,
    output logic                err_len,
    output logic                k_start,
    input  logic                k_done,
    input  logic [ADDR_WID-1:0] k_in_addr,
    input  logic                k_in_ce,
    output logic [DATA_WID-1:0] k_in_q,
    input  logic [ADDR_WID-1:0] k_out_addr,
    input  logic                k_out_ce,
    input  logic                k_out_we,
    input  logic [DATA_WID-1:0] k_out_d
`ifdef CYCLE_COUNTER_EN
    ,
    output logic [31:0]         cycle_count
`endif
);

    localparam int unsigned DEPTH   = 2 ** ADDR_WID;
    localparam int unsigned CNT_WID = ADDR_WID + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_RD_WAIT, S_RD_ACK, S_KSTART, S_KWAIT,
        S_WR_LOAD, S_WR_WAIT, S_WR_ACK, S_DONE
    } state_t;

    state_t               state;
    logic [CNT_WID-1:0]   idx;
    logic [CNT_WID-1:0]   num_q;
    logic [63:0]          step_q;
    logic [63:0]          wr_ptr;

    logic [DATA_WID-1:0]  inbuf  [DEPTH];
    logic [DATA_WID-1:0]  outbuf [DEPTH];

    logic                 len_over_c;
    logic [CNT_WID-1:0]   n_start_c;
    logic                 k_win_c;
    logic                 more_c;

    // Clamp the requested length to the buffer depth; the kernel owns the buffers only while running
    assign len_over_c = (num_words > 64'(DEPTH));
    assign n_start_c  = len_over_c ? CNT_WID'(DEPTH) : num_words[CNT_WID-1:0];
    assign k_win_c    = (state == S_KSTART) || (state == S_KWAIT);
    assign more_c     = ((idx + CNT_WID'(1)) < num_q);

    // Transfer sequencer: read phase, kernel handshake, write phase, done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            idx          <= '0;
            num_q        <= '0;
            step_q       <= '0;
            wr_ptr       <= '0;
            read_enable  <= 1'b0;
            read_addr    <= '0;
            read_size    <= '0;
            finish_read  <= 1'b0;
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_size   <= '0;
            finish_write <= 1'b0;
            write_data   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_len      <= 1'b0;
            k_start      <= 1'b0;
        end else begin
            finish_read  <= 1'b0;
            finish_write <= 1'b0;
            k_start      <= 1'b0;
            done         <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        err_len <= len_over_c;
                        num_q   <= n_start_c;
                        idx     <= '0;
                        step_q  <= step;
                        wr_ptr  <= write_base;
                        if (n_start_c == '0) begin
                            state <= S_DONE;
                        end else begin
                            state       <= S_RD_WAIT;
                            read_enable <= 1'b1;
                            read_addr   <= read_base;
                            read_size   <= step;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (read_ready) state <= S_RD_ACK;
                end
                S_RD_ACK: begin
                    if (more_c) begin
                        idx         <= idx + CNT_WID'(1);
                        read_addr   <= read_addr + step_q;
                        finish_read <= 1'b1;
                        state       <= S_RD_WAIT;
                    end else begin
                        read_enable <= 1'b0;
                        k_start     <= 1'b1;
                        state       <= S_KSTART;
                    end
                end
                S_KSTART: begin
                    state <= S_KWAIT;
                end
                S_KWAIT: begin
                    if (k_done) begin
                        idx   <= '0;
                        state <= S_WR_LOAD;
                    end
                end
                S_WR_LOAD: begin
                    write_data   <= outbuf[idx[ADDR_WID-1:0]];
                    write_addr   <= wr_ptr;
                    write_size   <= step_q;
                    write_enable <= 1'b1;
                    state        <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (write_ready) state <= S_WR_ACK;
                end
                S_WR_ACK: begin
                    if (more_c) begin
                        idx          <= idx + CNT_WID'(1);
                        wr_ptr       <= wr_ptr + step_q;
                        finish_write <= 1'b1;
                        state        <= S_WR_LOAD;
                    end else begin
                        write_enable <= 1'b0;
                        state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Input buffer capture of each accepted read word
    always_ff @(posedge clk) begin
        if (state == S_RD_WAIT && read_ready) inbuf[idx[ADDR_WID-1:0]] <= read_data;
    end

    // Output buffer written by the kernel while it owns the buffers
    always_ff @(posedge clk) begin
        if (k_win_c && k_out_ce && k_out_we) outbuf[k_out_addr] <= k_out_d;
    end

    // Kernel read port: one-cycle registered read, holds outside the kernel window
    always_ff @(posedge clk) begin
        if (reset) begin
            k_in_q <= '0;
        end else if (k_win_c && k_in_ce) begin
            k_in_q <= inbuf[k_in_addr];
        end
    end

`ifdef CYCLE_COUNTER_EN
    // Busy-cycle counter: cleared on accepted start, saturating, frozen once idle
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (state == S_IDLE && start) begin
            cycle_count <= '0;
        end else if (state != S_IDLE && cycle_count != 32'hFFFF_FFFF) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`else
    // Counter not built in this configuration.
`endif

endmodule

// File: tb/tb_accel_dma_shell.sv
// Bench for accel_dma_shell: random memory stalls, a bench kernel computing x+1,
// and a transaction-level model of expected reads and writes.
module tb_accel_dma_shell;

    localparam int unsigned DATA_WID = 32;
    localparam int unsigned ADDR_WID = 9;
    localparam int unsigned DEPTH    = 512;

    logic                clk;
    logic                reset;
    logic                start;
    logic [63:0]         read_base, write_base, num_words, step;
    logic                read_ready, write_ready;
    logic [DATA_WID-1:0] read_data;
    logic                read_enable, finish_read, write_enable, finish_write;
    logic [63:0]         read_addr, read_size, write_addr, write_size;
    logic [DATA_WID-1:0] write_data;
    logic                busy, done, err_len, k_start, k_done;
    logic [ADDR_WID-1:0] k_in_addr, k_out_addr;
    logic                k_in_ce, k_out_ce, k_out_we;
    logic [DATA_WID-1:0] k_in_q, k_out_d;
`ifdef CYCLE_COUNTER_EN
    logic [31:0]         cycle_count;
`endif

    accel_dma_shell #(.DATA_WID(DATA_WID), .ADDR_WID(ADDR_WID)) dut (
        .clk(clk), .reset(reset), .start(start),
        .read_base(read_base), .write_base(write_base), .num_words(num_words), .step(step),
        .read_ready(read_ready), .read_data(read_data), .write_ready(write_ready),
        .read_enable(read_enable), .read_addr(read_addr), .read_size(read_size),
        .finish_read(finish_read), .write_enable(write_enable), .write_addr(write_addr),
        .write_size(write_size), .finish_write(finish_write), .write_data(write_data),
        .busy(busy), .done(done), .err_len(err_len), .k_start(k_start), .k_done(k_done),
        .k_in_addr(k_in_addr), .k_in_ce(k_in_ce), .k_in_q(k_in_q),
        .k_out_addr(k_out_addr), .k_out_ce(k_out_ce), .k_out_we(k_out_we), .k_out_d(k_out_d)
`ifdef CYCLE_COUNTER_EN
        , .cycle_count(cycle_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference model of the current operation
    int          m_n;
    logic [63:0] m_rbase, m_wbase, m_step;
    logic        mon_on;
    int          rd_cnt, wr_cnt, fr_cnt, fw_cnt, ks_cnt, done_cnt;
    logic [63:0] wr_log_addr[$];
    logic [31:0] wr_log_data[$];
    int          stall_lo, stall_hi, kd_g;
    logic        kernel_mute;
    logic        rd_acc, wr_acc;

    // Memory contents as a pure function of the byte address
    function automatic logic [31:0] rd_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hCAFE0000;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Memory responder: one ready per request after a random stall, stray readies otherwise
    initial begin
        logic prev_re, prev_we, prev_fw, rd_pend, wr_pend;
        int   rd_wait, wr_wait;
        prev_re = 0; prev_we = 0; prev_fw = 0; rd_pend = 0; wr_pend = 0;
        rd_wait = 0; wr_wait = 0;
        read_ready = 0; write_ready = 0; read_data = '0; rd_acc = 0; wr_acc = 0;
        forever begin
            @(negedge clk);
            rd_acc = 0; wr_acc = 0; read_ready = 0; write_ready = 0;
            read_data = $urandom;
            if (reset) begin
                rd_pend = 0; wr_pend = 0;
            end else begin
                if (read_enable && (!prev_re || finish_read)) begin
                    rd_pend = 1;
                    rd_wait = int'($urandom_range(stall_hi, stall_lo));
                end
                if (rd_pend) begin
                    if (rd_wait == 0) begin
                        read_ready = 1; read_data = rd_word(read_addr); rd_acc = 1; rd_pend = 0;
                    end else rd_wait--;
                end else read_ready = ($urandom_range(2, 0) == 0);
                if (write_enable && (!prev_we || prev_fw)) begin
                    wr_pend = 1;
                    wr_wait = int'($urandom_range(stall_hi, stall_lo));
                end
                if (wr_pend) begin
                    if (wr_wait == 0) begin
                        write_ready = 1; wr_acc = 1; wr_pend = 0;
                    end else wr_wait--;
                end else write_ready = ($urandom_range(2, 0) == 0);
            end
            prev_re = read_enable; prev_we = write_enable; prev_fw = finish_write;
        end
    end

    // Bench kernel: out[i] = in[i] + 1, then k_done (pulsed or held); stray accesses while idle
    initial begin
        int el, hold;
        k_done = 0; k_in_ce = 0; k_out_ce = 0; k_out_we = 0;
        k_in_addr = '0; k_out_addr = '0; k_out_d = '0;
        forever begin
            @(negedge clk);
            k_in_ce = 0; k_out_ce = 0; k_out_we = 0;
            if (!kernel_mute && !reset) begin
                if (k_start) begin
                    el = 0;
                    for (int i = 0; i < m_n; i++) begin
                        k_in_addr = ADDR_WID'(i); k_in_ce = 1;
                        @(negedge clk); el++;
                        k_in_ce = 0;
                        k_out_addr = ADDR_WID'(i); k_out_ce = 1; k_out_we = 1;
                        k_out_d = k_in_q + 32'd1;
                        @(negedge clk); el++;
                        k_out_ce = 0; k_out_we = 0;
                    end
                    while (el < kd_g) begin @(negedge clk); el++; end
                    k_done = 1;
                    hold = int'($urandom_range(3, 1));
                    repeat (hold) @(negedge clk);
                    k_done = 0;
                end else if ($urandom_range(3, 0) == 0) begin
                    k_out_addr = ADDR_WID'($urandom); k_out_d = $urandom;
                    k_out_ce = 1; k_out_we = 1;
                    k_in_addr = ADDR_WID'($urandom); k_in_ce = 1;
                end
            end
        end
    end

    // Compare process: every accepted read/write against the model, pulse counting
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_on) begin
                if (rd_acc) begin
                    if (rd_cnt < m_n) begin
                        check("read_addr", read_addr, m_rbase + 64'(rd_cnt) * m_step);
                        check("read_size", read_size, m_step);
                    end else check("read_count_overrun", 64'(rd_cnt + 1), 64'(m_n));
                    rd_cnt++;
                end
                if (wr_acc) begin
                    wr_log_addr.push_back(write_addr);
                    wr_log_data.push_back(write_data);
                    if (wr_cnt < m_n) begin
                        check("write_addr", write_addr, m_wbase + 64'(wr_cnt) * m_step);
                        check("write_size", write_size, m_step);
                        check("write_data", 64'(write_data),
                              64'(rd_word(m_rbase + 64'(wr_cnt) * m_step) + 32'd1));
                    end else check("write_count_overrun", 64'(wr_cnt + 1), 64'(m_n));
                    wr_cnt++;
                end
                if (finish_read)  fr_cnt++;
                if (finish_write) fw_cnt++;
                if (k_start)      ks_cnt++;
                if (done)         done_cnt++;
            end
        end
    end

    task automatic arm_model(input int n, input logic [63:0] rb, wb, st, input int slo, shi, kd);
        m_n = n; m_rbase = rb; m_wbase = wb; m_step = st;
        stall_lo = slo; stall_hi = shi; kd_g = kd;
        rd_cnt = 0; wr_cnt = 0; fr_cnt = 0; fw_cnt = 0; ks_cnt = 0; done_cnt = 0;
        wr_log_addr.delete(); wr_log_data.delete();
        mon_on = 1;
    endtask

    task automatic run_op(input logic [63:0] nw, rb, wb, st, input int slo, shi, kd,
                          input bit mid_start, input longint want_cc);
        int n, lat;
        bit got_done;
        n = (nw > 64'(DEPTH)) ? int'(DEPTH) : int'(nw);
        @(negedge clk);
        arm_model(n, rb, wb, st, slo, shi, kd);
        num_words = nw; read_base = rb; write_base = wb; step = st; start = 1;
        lat = 0; got_done = 0;
        while (!got_done && lat < 20000) begin
            @(negedge clk);
            lat++;
            start = 0;
            read_base = {$urandom, $urandom}; write_base = {$urandom, $urandom};
            step = {$urandom, $urandom}; num_words = 64'($urandom_range(40, 0));
            if (mid_start && lat == 4) start = 1;
            #2;
            if (done) got_done = 1;
            if (lat == 3 && n > 0) check("busy_mid_op", 64'(busy), 64'd1);
        end
        check("done_seen", 64'(got_done), 64'd1);
        if (n == 0) check("zero_len_done_latency", 64'(lat), 64'd2);
        check("err_len_at_done", 64'(err_len), 64'(nw > 64'(DEPTH)));
`ifdef CYCLE_COUNTER_EN
        if (want_cc >= 0) check("cycle_count", 64'(cycle_count), 64'(want_cc));
`endif
        repeat (3) @(negedge clk);
        #2;
        check("reads_total", 64'(rd_cnt), 64'(n));
        check("writes_total", 64'(wr_cnt), 64'(n));
        check("finish_read_pulses", 64'(fr_cnt), 64'((n > 0) ? n - 1 : 0));
        check("finish_write_pulses", 64'(fw_cnt), 64'((n > 0) ? n - 1 : 0));
        check("k_start_pulses", 64'(ks_cnt), 64'((n > 0) ? 1 : 0));
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("busy_after_done", 64'(busy), 64'd0);
        check("err_len_sticky", 64'(err_len), 64'(nw > 64'(DEPTH)));
`ifdef CYCLE_COUNTER_EN
        if (want_cc >= 0) check("cycle_count_frozen", 64'(cycle_count), 64'(want_cc));
`endif
        mon_on = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_read_enable"}, 64'(read_enable), 64'd0);
        check({tag, "_read_addr"}, read_addr, 64'd0);
        check({tag, "_read_size"}, read_size, 64'd0);
        check({tag, "_finish_read"}, 64'(finish_read), 64'd0);
        check({tag, "_write_enable"}, 64'(write_enable), 64'd0);
        check({tag, "_write_addr"}, write_addr, 64'd0);
        check({tag, "_write_size"}, write_size, 64'd0);
        check({tag, "_finish_write"}, 64'(finish_write), 64'd0);
        check({tag, "_write_data"}, 64'(write_data), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err_len"}, 64'(err_len), 64'd0);
        check({tag, "_k_start"}, 64'(k_start), 64'd0);
        check({tag, "_k_in_q"}, 64'(k_in_q), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic [63:0] nw, rb, wb, st;
        reset = 1; start = 0; read_base = '0; write_base = '0; num_words = '0; step = '0;
        mon_on = 0; kernel_mute = 0; m_n = 0; stall_lo = 0; stall_hi = 0; kd_g = 0;
        m_rbase = '0; m_wbase = '0; m_step = '0;
        repeat (3) @(negedge clk);
        #2;
        check_zero("reset");
        reset = 0;

        // Directed: 4 words, base 0x1000 step 4, memory ready one cycle after the request
        run_op(64'd4, 64'h1000, 64'h2000, 64'd4, 1, 1, 6, 1'b0, -1);
        check("log_size_4", 64'(wr_log_addr.size()), 64'd4);
        if (wr_log_addr.size() == 4) begin
            check("lit_waddr0", wr_log_addr[0], 64'h2000);
            check("lit_waddr3", wr_log_addr[3], 64'h200C);
            check("lit_wdata0", 64'(wr_log_data[0]), 64'hCAFE1001);
            check("lit_wdata3", 64'(wr_log_data[3]), 64'hCAFE100D);
        end

        // Zero length: done two cycles after start, no memory or kernel activity
        run_op(64'd0, 64'h3000, 64'h4000, 64'd4, 0, 0, 3, 1'b0, -1);

        // Address wrap across 2**64 with stalls and an ignored start while busy
        run_op(64'd5, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 64'd4, 0, 7, 2, 1'b1, -1);

        // Random operations
        for (int t = 0; t < 6; t++) begin
            nw = 64'($urandom_range(24, 1));
            rb = {$urandom, $urandom};
            wb = {$urandom, $urandom};
            st = ($urandom_range(3, 0) == 0) ? {$urandom, $urandom} : 64'($urandom_range(16, 0) * 4);
            run_op(nw, rb, wb, st, 0, 7, int'($urandom_range(30, 0)), 1'b1, -1);
        end

        // Oversize request: clamped to DEPTH with err_len
        run_op(64'(DEPTH + 3), 64'h10000, 64'h8000, 64'd8, 0, 0, 4, 1'b0, -1);
        check("oversize_log_size", 64'(wr_log_addr.size()), 64'(DEPTH));
        if (wr_log_addr.size() == DEPTH)
            check("oversize_last_waddr", wr_log_addr[DEPTH-1], 64'h8FF8);

        // Reset while waiting on the kernel: immediate abort, no done
        kernel_mute = 1;
        @(negedge clk);
        arm_model(int'(DEPTH), 64'h40000, 64'h50000, 64'd4, 0, 0, 0);
        num_words = 64'(DEPTH + 1); read_base = 64'h40000; write_base = 64'h50000; step = 64'd4;
        start = 1;
        @(negedge clk);
        start = 0;
        seen = 0;
        for (int c = 0; c < 5000 && seen == 0; c++) begin
            @(negedge clk);
            #2;
            if (k_start) seen = 1;
        end
        check("k_start_before_reset", 64'(seen), 64'd1);
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);
        #2;
        check_zero("abort");
        @(negedge clk);
        reset = 0;
        kernel_mute = 0;
        repeat (5) @(negedge clk);
        #2;
        check("no_done_after_abort", 64'(done_cnt), 64'd0);
        check("reads_before_abort", 64'(rd_cnt), 64'(DEPTH));
        mon_on = 0;
        run_op(64'd3, 64'h700, 64'h900, 64'd12, 0, 4, 3, 1'b1, -1);

`ifdef CYCLE_COUNTER_EN
        // N=1, zero stall, k_done 5 cycles after k_start:
        // RD_WAIT 1 + RD_ACK 1 + KSTART 1 + KWAIT 5 + WR_LOAD 1 + WR_WAIT 1 + WR_ACK 1 + DONE 1 = 12
        run_op(64'd1, 64'h500, 64'h600, 64'd4, 0, 0, 5, 1'b0, 12);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
